// File: rtl/and_cell_scheduler.sv
// Round-robin scheduler sharing one clocked AND cell between two requesters.
// Operands are held around a single cell_clk pulse with fixed setup/hold spacing.
module and_cell_scheduler #(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned HOLD_CYC  = 1,
    parameter int unsigned CAP_CYC   = 1,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req0_a,
    input  logic             req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic             req1_a,
    input  logic             req1_b,
    output logic             req1_ready,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic             rsp_out,
    input  logic             rsp_ready,
    output logic             cell_a,
    output logic             cell_b,
    output logic             cell_clk,
    input  logic             cell_out,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);

    localparam int unsigned MAX_SH  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int unsigned MAX_CYC = (MAX_SH > CAP_CYC) ? MAX_SH : CAP_CYC;
    localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_CAPTURE,
        S_RESP
    } state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               last_grant_q, last_grant_d;
    logic               cell_a_q, cell_a_d;
    logic               cell_b_q, cell_b_d;
    logic               cell_clk_q, cell_clk_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_id_q, rsp_id_d;
    logic               rsp_out_q, rsp_out_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   done_cnt_q, done_cnt_d;
    logic               idle_c;

    // Grant only in IDLE and never while reset is held; a tie goes to the other index.
    assign idle_c     = rst_n && (state_q == S_IDLE);
    assign req0_ready = idle_c && req0_valid && (!req1_valid || last_grant_q);
    assign req1_ready = idle_c && req1_valid && (!req0_valid || !last_grant_q);

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        last_grant_d = last_grant_q;
        cell_a_d     = cell_a_q;
        cell_b_d     = cell_b_q;
        cell_clk_d   = 1'b0;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_out_d    = rsp_out_q;
        done_cnt_d   = done_cnt_q;
        busy_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req0_ready || req1_ready) begin
                    last_grant_d = req1_ready;
                    cell_a_d     = req1_ready ? req1_a : req0_a;
                    cell_b_d     = req1_ready ? req1_b : req0_b;
                    tmr_d        = TMR_W'(SETUP_CYC);
                    state_d      = S_SETUP;
                end
            end
            S_SETUP: begin
                if (tmr_q == TMR_W'(1)) begin
                    cell_clk_d = 1'b1;
                    state_d    = S_STROBE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_STROBE: begin
                tmr_d   = TMR_W'(HOLD_CYC);
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (tmr_q == TMR_W'(1)) begin
                    cell_a_d = 1'b0;
                    cell_b_d = 1'b0;
                    tmr_d    = TMR_W'(CAP_CYC);
                    state_d  = S_CAPTURE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_CAPTURE: begin
                if (tmr_q == TMR_W'(1)) begin
                    // last_grant_q still names the owner of the operation in flight
                    rsp_out_d   = cell_out;
                    rsp_id_d    = last_grant_q;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    done_cnt_d  = done_cnt_q + CNT_W'(1);
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            tmr_q        <= '0;
            last_grant_q <= 1'b1;
            cell_a_q     <= 1'b0;
            cell_b_q     <= 1'b0;
            cell_clk_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_out_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            last_grant_q <= last_grant_d;
            cell_a_q     <= cell_a_d;
            cell_b_q     <= cell_b_d;
            cell_clk_q   <= cell_clk_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_out_q    <= rsp_out_d;
            busy_q       <= busy_d;
            done_cnt_q   <= done_cnt_d;
        end
    end

    assign cell_a    = cell_a_q;
    assign cell_b    = cell_b_q;
    assign cell_clk  = cell_clk_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_out   = rsp_out_q;
    assign busy      = busy_q;
    assign done_cnt  = done_cnt_q;

endmodule
